// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
package lsu_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} lsu_state_e;
    localparam int DWORD_BYTES = 8;
    localparam int WORD_BYTES  = 4;
    localparam int LSU_DEPTH   = 10;
endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - word extraction (sign-extended) and word merge into a dword
module lsu_align
    import lsu_pkg::*;
(
    input  logic [63:0] i_dword,
    input  logic        i_hi,
    input  logic [31:0] i_wword,
    output logic [63:0] o_load_word,
    output logic [63:0] o_merged
);
    localparam int WB = 8 * WORD_BYTES;

    logic [WB-1:0] w_half;

    assign w_half      = i_hi ? i_dword[2*WB-1:WB] : i_dword[WB-1:0];
    assign o_load_word = {{WB{w_half[WB-1]}}, w_half};
    assign o_merged    = i_hi ? {i_wword, i_dword[WB-1:0]} : {i_dword[2*WB-1:WB], i_wword};
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator with word read-modify-write stores
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH = LSU_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic        req_dword,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    output logic        mem_type,
    input  logic [63:0] mem_rdata
);
    localparam logic [63:0] LIMIT = 64'(DEPTH * DWORD_BYTES);

    lsu_state_e  r_state;
    logic        r_store;
    logic        r_dword;
    logic [61:0] r_addr;      // byte address without bits [1:0], never needed after the check
    logic [63:0] r_wdata;
    logic [63:0] r_merged;
    logic [63:0] r_rdata;
    logic        r_err;

    logic        w_bad;
    logic        w_busy;
    logic        w_wr_cycle;
    logic [63:0] w_load_word;
    logic [63:0] w_merged;

    lsu_align u_align (
        .i_dword     (mem_rdata),
        .i_hi        (r_addr[0]),
        .i_wword     (r_wdata[31:0]),
        .o_load_word (w_load_word),
        .o_merged    (w_merged)
    );

    assign w_bad = (req_dword ? (req_addr[2:0] != 3'd0) : (req_addr[1:0] != 2'd0))
                   || (req_addr >= LIMIT);

    assign w_busy     = (r_state == ACCESS) || (r_state == WRITE);
    assign w_wr_cycle = ((r_state == ACCESS) && r_store && r_dword) || (r_state == WRITE);

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_type   = 1'b1;
    assign mem_addr   = w_busy ? {r_addr[61:1], 3'b000} : 64'd0;
    assign mem_wdata  = (r_state == WRITE) ? r_merged :
                        (w_wr_cycle ? r_wdata : 64'd0);
    // Gated by rst so a write can never commit on a reset edge.
    assign mem_wr     = w_wr_cycle && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_store  <= 1'b0;
            r_dword  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_merged <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_store <= req_store;
                        r_dword <= req_dword;
                        r_addr  <= req_addr[63:2];
                        r_wdata <= req_wdata;
                        r_rdata <= '0;
                        r_err   <= w_bad;
                        r_state <= w_bad ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    if (!r_store) begin
                        r_rdata <= r_dword ? mem_rdata : w_load_word;
                        r_state <= RESP;
                    end else if (r_dword) begin
                        r_state <= RESP;
                    end else begin
                        r_merged <= w_merged;
                        r_state  <= WRITE;
                    end
                end
                WRITE: r_state <= RESP;
                RESP: begin
                    if (resp_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
    localparam int DEPTH = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic        req_store = 1'b0, req_dword = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr, mem_type;

    logic [63:0] mem     [DEPTH];
    logic [63:0] ref_mem [DEPTH];
    logic        pl_en = 1'b0;
    int          pl_idx = 0;
    logic [63:0] pl_val = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_dword(req_dword), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr(mem_wr), .mem_type(mem_type), .mem_rdata(mem_rdata)
    );

    // Memory: combinational read, write commits on the edge ending the mem_wr cycle
    always_comb begin
        mem_rdata = '0;
        if (mem_addr[63:3] < 61'(DEPTH)) mem_rdata = mem[int'(mem_addr[63:3])];
    end

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (mem_wr && mem_addr[63:3] < 61'(DEPTH)) mem[int'(mem_addr[63:3])] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [63:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Reference: requests judged by byte arithmetic on a flat dword array
    task automatic ref_op(input logic st, input logic dw, input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] rd, output logic er, output int lat, output int wrm);
        int          idx, sh;
        logic [31:0] w;
        rd  = '0;
        wrm = 0;
        er  = ((a % (dw ? 64'd8 : 64'd4)) != 0) || (a >= 64'(8 * DEPTH));
        if (er) begin
            lat = 1;
            return;
        end
        idx = int'(a / 8);
        sh  = int'(a % 8) * 8;
        if (!st && dw) begin
            rd = ref_mem[idx]; lat = 2;
        end else if (!st) begin
            w = 32'(ref_mem[idx] >> sh);
            rd = 64'($signed(w)); lat = 2;
        end else if (dw) begin
            ref_mem[idx] = wd; lat = 2; wrm = 2;
        end else begin
            ref_mem[idx] = (ref_mem[idx] & ~(64'hFFFF_FFFF << sh)) | ({32'd0, wd[31:0]} << sh);
            lat = 3; wrm = 4;
        end
    endtask

    task automatic do_req(input logic st, input logic dw, input logic [63:0] a, input logic [63:0] wd,
                          input int hold, output logic [63:0] rd, output logic er,
                          output int lat, output int wrm);
        int cyc;
        rd = '0; er = 1'b0; lat = -1; wrm = 0;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_dword = dw; req_addr = a; req_wdata = wd;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (lat < 0 && cyc < 20) begin
            if (mem_wr) wrm |= (1 << cyc);
            if (resp_valid) begin
                lat = cyc; rd = resp_rdata; er = resp_err;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (lat < 0) begin
            chk("resp_timeout", 64'(cyc), 64'd0);
            return;
        end
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_store = 1'b1; req_dword = 1'b1; req_addr = 64'd8;
            @(posedge clk); #1;
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_rdata", resp_rdata, rd);
            chk("hold_err", 64'(resp_err), 64'(er));
            chk("hold_ready", 64'(req_ready), 64'd0);
            chk("hold_wr", 64'(mem_wr), 64'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("done_valid", 64'(resp_valid), 64'd0);
        chk("done_ready", 64'(req_ready), 64'd1);
    endtask

    typedef struct {
        logic        st;
        logic        dw;
        logic [63:0] a;
        logic [63:0] wd;
        int          hold;
        logic [63:0] rd;
        logic        er;
        int          lat;
        int          wrm;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [63:0] rd, erd;
        logic        er, eer;
        int          lat, elat, wrm, ewrm;
        logic [63:0] a, wd;
        logic        st, dw;

        vecs[0]  = '{0, 0, 64'd8,  64'd0, 0, 64'hFFFF_FFFF_8000_0002, 0, 2, 0};
        vecs[1]  = '{0, 0, 64'd12, 64'd0, 0, 64'h0000_0000_0000_0001, 0, 2, 0};
        vecs[2]  = '{1, 1, 64'd16, 64'hDEAD_BEEF_0123_4567, 0, 64'd0, 0, 2, 2};
        vecs[3]  = '{0, 1, 64'd16, 64'd0, 0, 64'hDEAD_BEEF_0123_4567, 0, 2, 0};
        vecs[4]  = '{1, 0, 64'd4,  64'h5555_5555_AAAA_BBBB, 0, 64'd0, 0, 3, 4};
        vecs[5]  = '{0, 1, 64'd0,  64'd0, 0, 64'hAAAA_BBBB_2222_2222, 0, 2, 0};
        vecs[6]  = '{0, 1, 64'd4,  64'd0, 0, 64'd0, 1, 1, 0};
        vecs[7]  = '{0, 0, 64'd2,  64'd0, 0, 64'd0, 1, 1, 0};
        vecs[8]  = '{0, 0, 64'd80, 64'd0, 0, 64'd0, 1, 1, 0};
        vecs[9]  = '{1, 1, 64'd80, 64'h1234, 0, 64'd0, 1, 1, 0};
        vecs[10] = '{1, 0, 64'd76, 64'h1234, 0, 64'd0, 0, 3, 4};
        vecs[11] = '{0, 1, 64'd72, 64'd0, 0, 64'h0000_1234_9999_0000, 0, 2, 0};
        vecs[12] = '{0, 0, 64'd0,  64'd0, 5, 64'h0000_0000_2222_2222, 0, 2, 0};

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        chk("rst_mem_wr", 64'(mem_wr), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("mem_type", 64'(mem_type), 64'd1);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) preload(i, 64'(i) * 64'h0101_0101_0101_0101);
        preload(0, 64'h1111_1111_2222_2222);
        preload(1, 64'h0000_0001_8000_0002);
        preload(9, 64'h0000_0000_9999_0000);

        foreach (vecs[i]) begin
            ref_op(vecs[i].st, vecs[i].dw, vecs[i].a, vecs[i].wd, erd, eer, elat, ewrm);
            do_req(vecs[i].st, vecs[i].dw, vecs[i].a, vecs[i].wd, vecs[i].hold, rd, er, lat, wrm);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
            chk($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].er));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("vec%0d_wr", i), 64'(wrm), 64'(vecs[i].wrm));
        end
        chk("entry0_merged", mem[0], 64'hAAAA_BBBB_2222_2222);

        // Reset during the WRITE cycle of a word store
        preload(3, 64'h3333_3333_4444_4444);
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_dword = 1'b0;
        req_addr = 64'd24; req_wdata = 64'h9999_9999;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rmw_c1_wr", 64'(mem_wr), 64'd0);
        @(posedge clk); #1;
        chk("rmw_c2_wr", 64'(mem_wr), 64'd1);
        chk("rmw_c2_addr", mem_addr, 64'd24);
        rst = 1'b1;
        #1;
        chk("rmw_rst_wr", 64'(mem_wr), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rmw_rst_mem", mem[3], 64'h3333_3333_4444_4444);
        chk("rmw_rst_valid", 64'(resp_valid), 64'd0);
        chk("rmw_rst_ready", 64'(req_ready), 64'd1);
        do_req(1'b0, 1'b1, 64'd24, 64'd0, 0, rd, er, lat, wrm);
        chk("rmw_rst_load", rd, 64'h3333_3333_4444_4444);

        for (int n = 0; n < 80; n++) begin
            st = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            wd = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0:       a = 64'($urandom_range(0, 8 * DEPTH + 15));
                1:       a = {$urandom, $urandom};
                default: a = 64'($urandom_range(0, 2 * DEPTH - 1)) * 64'd4;
            endcase
            ref_op(st, dw, a, wd, erd, eer, elat, ewrm);
            do_req(st, dw, a, wd, int'($urandom_range(0, 2)), rd, er, lat, wrm);
            chk($sformatf("rnd%0d_rdata", n), rd, erd);
            chk($sformatf("rnd%0d_err", n), 64'(er), 64'(eer));
            chk($sformatf("rnd%0d_lat", n), 64'(lat), 64'(elat));
            chk($sformatf("rnd%0d_wr", n), 64'(wrm), 64'(ewrm));
        end
        for (int i = 0; i < DEPTH; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
